// File: rtl/debug_uart_dumper.sv
// Reads register-file words through the datapath debug port and sends each
// word as four 8N1 UART bytes, most significant byte first.
module debug_uart_dumper #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        single,
    input  logic [4:0]  reg_sel,
    output logic [4:0]  Debug_Source_select,
    input  logic [31:0] Debug_output,
    output logic        tx,
    output logic        busy,
    output logic        done
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE, SELECT, CAPTURE, START_BIT, DATA_BITS, STOP_BIT, FINISH
    } state_t;

    state_t        state_reg, state_next;
    logic          single_reg, single_next;
    logic [4:0]    index_reg, index_next;
    logic [31:0]   word_reg, word_next;
    logic [1:0]    byte_cnt_reg, byte_cnt_next;
    logic [2:0]    bit_cnt_reg, bit_cnt_next;
    logic [BW-1:0] baud_cnt_reg, baud_cnt_next;

    logic [7:0] word_bytes [4];
    logic [7:0] cur_byte;
    logic       baud_last;

    // Byte 0 is the top byte of the word so the MSB byte leaves first.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_bytes
            assign word_bytes[gi] = word_reg[31-8*gi -: 8];
        end
    endgenerate

    assign cur_byte            = word_bytes[byte_cnt_reg];
    assign baud_last           = (baud_cnt_reg == BAUD_LAST);
    assign Debug_Source_select = index_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            single_reg   <= 1'b0;
            index_reg    <= 5'd0;
            word_reg     <= 32'd0;
            byte_cnt_reg <= 2'd0;
            bit_cnt_reg  <= 3'd0;
            baud_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            single_reg   <= single_next;
            index_reg    <= index_next;
            word_reg     <= word_next;
            byte_cnt_reg <= byte_cnt_next;
            bit_cnt_reg  <= bit_cnt_next;
            baud_cnt_reg <= baud_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        single_next   = single_reg;
        index_next    = index_reg;
        word_next     = word_reg;
        byte_cnt_next = byte_cnt_reg;
        bit_cnt_next  = bit_cnt_reg;
        baud_cnt_next = baud_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    single_next = single;
                    index_next  = single ? reg_sel : 5'd0;
                    state_next  = SELECT;
                end
            end
            SELECT: state_next = CAPTURE;
            CAPTURE: begin
                word_next     = Debug_output;
                byte_cnt_next = 2'd0;
                bit_cnt_next  = 3'd0;
                baud_cnt_next = '0;
                state_next    = START_BIT;
            end
            START_BIT: begin
                if (baud_last) begin
                    baud_cnt_next = '0;
                    bit_cnt_next  = 3'd0;
                    state_next    = DATA_BITS;
                end else begin
                    baud_cnt_next = baud_cnt_reg + 1'b1;
                end
            end
            DATA_BITS: begin
                if (baud_last) begin
                    baud_cnt_next = '0;
                    bit_cnt_next  = bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7) begin
                        state_next = STOP_BIT;
                    end
                end else begin
                    baud_cnt_next = baud_cnt_reg + 1'b1;
                end
            end
            STOP_BIT: begin
                if (baud_last) begin
                    baud_cnt_next = '0;
                    if (byte_cnt_reg != 2'd3) begin
                        byte_cnt_next = byte_cnt_reg + 2'd1;
                        state_next    = START_BIT;
                    end else if (!single_reg && index_reg != 5'd31) begin
                        index_next = index_reg + 5'd1;
                        state_next = SELECT;
                    end else begin
                        state_next = FINISH;
                    end
                end else begin
                    baud_cnt_next = baud_cnt_reg + 1'b1;
                end
            end
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        tx   = 1'b1;
        busy = 1'b0;
        done = 1'b0;
        case (state_reg)
            SELECT, CAPTURE, STOP_BIT: busy = 1'b1;
            START_BIT: begin
                tx   = 1'b0;
                busy = 1'b1;
            end
            DATA_BITS: begin
                tx   = cur_byte[bit_cnt_reg];
                busy = 1'b1;
            end
            FINISH:  done = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_debug_uart_dumper.sv
// Scoreboard bench for debug_uart_dumper: stimulus queues expected frames and
// done pulses, independent monitors decode tx and done and compare.
module tb_debug_uart_dumper;
    localparam int C       = 4;
    localparam int REG_CYC = 2 + 40 * C;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        single = 1'b0;
    logic [4:0]  reg_sel = 5'd0;
    logic [4:0]  dss;
    logic [31:0] debug_output;
    logic        tx, busy, done;

    logic [31:0] mem [32];
    int cyc = 0;
    int tests_run = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] data;
        int         start_cyc;
        logic [4:0] sel;
    } frame_t;

    frame_t exp_q[$];
    int     done_q[$];

    debug_uart_dumper #(.CLKS_PER_BIT(C)) dut (
        .clk                 (clk),
        .reset               (reset),
        .start               (start),
        .single              (single),
        .reg_sel             (reg_sel),
        .Debug_Source_select (dss),
        .Debug_output        (debug_output),
        .tx                  (tx),
        .busy                (busy),
        .done                (done)
    );

    assign debug_output = mem[dss];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // UART monitor: decodes every frame cycle-exactly and compares with the queue.
    initial begin : uart_mon
        logic       prev_tx;
        logic [9:0] bits;
        logic [4:0] sel_at;
        int         start_c;
        int         unstable;
        bit         aborted;
        frame_t     e;
        prev_tx = 1'b1;
        forever begin
            @(negedge clk);
            if (reset !== 1'b0) begin
                prev_tx = 1'b1;
            end else if (tx === 1'b0 && prev_tx === 1'b1) begin
                start_c  = cyc;
                sel_at   = dss;
                bits     = '0;
                unstable = 0;
                aborted  = 1'b0;
                for (int k = 0; k < 10 && !aborted; k++) begin
                    for (int s = 0; s < C && !aborted; s++) begin
                        if (k != 0 || s != 0) begin
                            @(negedge clk);
                            if (reset !== 1'b0) aborted = 1'b1;
                        end
                        if (!aborted) begin
                            if (s == 0) bits[k] = tx;
                            else if (tx !== bits[k]) unstable++;
                        end
                    end
                end
                if (aborted) begin
                    prev_tx = 1'b1;
                end else begin
                    prev_tx = tx;
                    if (exp_q.size() == 0) begin
                        tests_run++;
                        failures++;
                        $display("FAIL unexpected_frame: got byte 0x%02h at cycle %0d, expected none",
                                 bits[8:1], start_c);
                    end else begin
                        e = exp_q.pop_front();
                        $display("[TB] frame 0x%02h start cycle %0d sel %0d", bits[8:1], start_c, sel_at);
                        check("frame_bits", 32'(bits), 32'({1'b1, e.data, 1'b0}));
                        check("frame_start_cycle", start_c, e.start_cyc);
                        check("frame_sel", 32'(sel_at), 32'(e.sel));
                        check("bit_stable", unstable, 0);
                    end
                end
            end else begin
                prev_tx = tx;
            end
        end
    end

    initial begin : done_mon
        int e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (done_q.size() == 0) begin
                    tests_run++;
                    failures++;
                    $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
                end else begin
                    e = done_q.pop_front();
                    $display("[TB] done at cycle %0d", cyc);
                    check("done_cycle", cyc, e);
                end
            end
        end
    end

    task automatic issue_start(input logic s, input logic [4:0] idx, output int n);
        start   = 1'b1;
        single  = s;
        reg_sel = idx;
        n       = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic push_word(input int sel_cyc, input logic [4:0] idx);
        frame_t f;
        for (int b = 0; b < 4; b++) begin
            f.data      = 8'(mem[idx] >> (24 - 8 * b));
            f.start_cyc = sel_cyc + 2 + 10 * C * b;
            f.sel       = idx;
            exp_q.push_back(f);
        end
    endtask

    task automatic wait_drain(input int budget);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || done_q.size() != 0) && k < budget) begin
            @(negedge clk);
            k++;
        end
        tests_run++;
        if (exp_q.size() != 0 || done_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d frames and %0d dones outstanding after %0d cycles, expected 0",
                     exp_q.size(), done_q.size(), budget);
        end
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("[TB] %0d tests run, %0d failed", tests_run, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n, n2, low;
        for (int i = 0; i < 32; i++) mem[i] = 32'h0100_0000 * i + i;

        // Asynchronous reset from an unknown state, mid-cycle.
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_sel", 32'(dss), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Single dump of register 5.
        mem[5] = 32'hDEAD_BEEF;
        issue_start(1'b1, 5'd5, n);
        check("single_busy_select", 32'(busy), 32'd1);
        check("single_sel", 32'(dss), 32'd5);
        push_word(n, 5'd5);
        done_q.push_back(n + REG_CYC);
        wait_drain(400);
        repeat (5) @(negedge clk);

        // Full sweep; reg_sel must be ignored.
        for (int i = 0; i < 32; i++) mem[i] = 32'h0100_0000 * i + i;
        issue_start(1'b0, 5'd17, n);
        check("sweep_sel_first", 32'(dss), 32'd0);
        for (int w = 0; w < 32; w++) push_word(n + w * REG_CYC, 5'(w));
        done_q.push_back(n + 32 * REG_CYC);
        wait_drain(6000);
        repeat (5) @(negedge clk);

        // Start pulse during byte 2 of a single dump must be ignored.
        mem[3] = 32'h3C5A_A5C3;
        mem[9] = 32'h9999_9999;
        issue_start(1'b1, 5'd3, n);
        push_word(n, 5'd3);
        done_q.push_back(n + REG_CYC);
        while (cyc < n + 2 + 80 + 8) @(negedge clk);
        start = 1'b1; single = 1'b1; reg_sel = 5'd9;
        @(negedge clk);
        start = 1'b0;
        wait_drain(400);
        repeat (200) @(negedge clk);
        check("busy_after_ignored_start", 32'(busy), 32'd0);

        // Reset during DATA_BITS of an all-zero byte.
        mem[6] = 32'h0000_0000;
        issue_start(1'b1, 5'd6, n);
        push_word(n, 5'd6);
        done_q.push_back(n + REG_CYC);
        while (cyc < n + 10) @(negedge clk);
        check("midbyte_tx_low", 32'(tx), 32'd0);
        check("midbyte_busy", 32'(busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("midreset_tx", 32'(tx), 32'd1);
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_done", 32'(done), 32'd0);
        check("midreset_sel", 32'(dss), 32'd0);
        exp_q.delete();
        done_q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        mem[1] = 32'h1234_5678;
        issue_start(1'b1, 5'd1, n);
        push_word(n, 5'd1);
        done_q.push_back(n + REG_CYC);
        wait_drain(400);
        repeat (5) @(negedge clk);

        // Back-to-back: start held high across two dumps.
        mem[7] = 32'h7E81_00FF;
        start = 1'b1; single = 1'b1; reg_sel = 5'd7;
        n  = cyc + 1;
        n2 = n + REG_CYC + 2;
        push_word(n, 5'd7);
        done_q.push_back(n + REG_CYC);
        push_word(n2, 5'd7);
        done_q.push_back(n2 + REG_CYC);
        low = 0;
        @(negedge clk);
        while (cyc < n2) begin
            @(negedge clk);
            if (busy === 1'b0) low++;
        end
        check("b2b_busy_low_cycles", low, 2);
        check("b2b_second_busy", 32'(busy), 32'd1);
        while (cyc < n2 + REG_CYC) @(negedge clk);
        start = 1'b0;
        wait_drain(400);
        repeat (20) @(negedge clk);
        check("b2b_idle_busy", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end
endmodule
